// File: rtl/poly_eval_sched_if.sv
// Requester/result bus for the shared polynomial evaluator.
// The master side presents operand sets; the slave side grants and reports results.
interface poly_eval_sched_if #(
    parameter int W = 8
);
    logic [1:0]     req;
    logic [4*W-1:0] op0;
    logic [4*W-1:0] op1;
    logic [1:0]     ack;
    logic [W-1:0]   data_result;
    logic           result_valid;
    logic           result_id;
    logic           busy;

    modport master (
        output req, op0, op1,
        input  ack, data_result, result_valid, result_id, busy
    );

    modport slave (
        input  req, op0, op1,
        output ack, data_result, result_valid, result_id, busy
    );
endinterface

// File: rtl/poly_eval_sched.sv
// Two-requester round-robin scheduler evaluating R = A*X*X + B*X + C
// on a single shared add/multiply ALU, one operation per cycle, mod 2^W.
module poly_eval_sched #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    poly_eval_sched_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_C0, S_C1, S_C2, S_C3, S_C4, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a, b, c, x;
    logic [W-1:0]   res;
    logic           res_id;
    logic           g;
    logic           last;
    logic           grant_nxt;

    logic [W-1:0]   alu_a, alu_b, alu_y, prod, sum;
    logic           alu_mul;

    // Ties go to whoever was not granted last; a lone requester always wins.
    always_comb begin
        grant_nxt = last;
        case (bus.req)
            2'b01:   grant_nxt = 1'b0;
            2'b10:   grant_nxt = 1'b1;
            2'b11:   grant_nxt = ~last;
            default: grant_nxt = last;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|bus.req) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_C0;
            S_C0:    state_nxt = S_C1;
            S_C1:    state_nxt = S_C2;
            S_C2:    state_nxt = S_C3;
            S_C3:    state_nxt = S_C4;
            S_C4:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand steering for the single shared ALU.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_mul = 1'b0;
        case (state)
            S_C0, S_C1: begin alu_a = a; alu_b = x; alu_mul = 1'b1; end
            S_C2:       begin alu_a = b; alu_b = x; alu_mul = 1'b1; end
            S_C3:       begin alu_a = a; alu_b = b; end
            S_C4:       begin alu_a = a; alu_b = c; end
            default:    ;
        endcase
    end

    assign prod  = alu_a * alu_b;
    assign sum   = alu_a + alu_b;
    assign alu_y = alu_mul ? prod : sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            c      <= '0;
            x      <= '0;
            res    <= '0;
            res_id <= 1'b0;
            g      <= 1'b0;
            last   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (|bus.req) begin
                    g    <= grant_nxt;
                    last <= grant_nxt;
                end
                S_LOAD:     {a, b, c, x} <= g ? bus.op1 : bus.op0;
                S_C0, S_C1: a <= alu_y;
                S_C2:       b <= alu_y;
                S_C3:       a <= alu_y;
                S_C4: begin
                    res    <= alu_y;
                    res_id <= g;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack          = (state == S_LOAD) ? (g ? 2'b10 : 2'b01) : 2'b00;
    assign bus.result_valid = (state == S_DONE);
    assign bus.busy         = (state != S_IDLE);
    assign bus.data_result  = res;
    assign bus.result_id    = res_id;
endmodule

// File: tb/tb_poly_eval_sched.sv
// Directed and random-operand bench for poly_eval_sched.
module tb_poly_eval_sched;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    poly_eval_sched_if #(.W(W)) bus();
    poly_eval_sched #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4*W-1:0] pk(input logic [W-1:0] a, b, c, x);
        return {a, b, c, x};
    endfunction

    function automatic logic [W-1:0] model(input logic [4*W-1:0] op);
        logic [W-1:0] a, b, c, x;
        {a, b, c, x} = op;
        return a * x * x + b * x + c;
    endfunction

    task automatic wait_ack(input int lim, output logic [1:0] a, output int c, output bit to);
        to = 1'b1; a = '0; c = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (bus.ack !== 2'b00) begin a = bus.ack; c = cyc; to = 1'b0; break; end
        end
    endtask

    task automatic wait_rv(input int lim, output int c, output bit to);
        to = 1'b1; c = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin c = cyc; to = 1'b0; break; end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 2'b00; bus.op0 = '0; bus.op1 = '0;
        #1;
        n_checks++;
        if ({bus.ack, bus.result_valid, bus.busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {bus.ack, bus.result_valid, bus.busy});
        end
        n_checks++;
        if ({bus.data_result, bus.result_id} !== 9'd0) begin
            n_fail++; $display("FAIL reset_data: got %0d/%0d want 0/0", bus.data_result, bus.result_id);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_basic();
        logic [1:0] a; int ca, cr; bit to;
        bus.req = 2'b01; bus.op0 = pk(8'd1, 8'd2, 8'd3, 8'd4);
        wait_ack(5, a, ca, to);
        n_checks++;
        if (to || a !== 2'b01) begin n_fail++; $display("FAIL basic_ack: got %b want 01", a); end
        @(posedge clk); #1;
        bus.req = 2'b00;
        @(negedge clk);
        n_checks++;
        if (bus.ack !== 2'b00 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_ack_pulse: ack %b busy %b want 00 1", bus.ack, bus.busy);
        end
        wait_rv(12, cr, to);
        n_checks++;
        if (to || cr - ca != 6) begin n_fail++; $display("FAIL basic_latency: got %0d want 6", cr - ca); end
        n_checks++;
        if (bus.data_result !== 8'd27 || bus.result_id !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: got %0d id %b want 27 id 0", bus.data_result, bus.result_id);
        end
        @(negedge clk);
        n_checks++;
        if (bus.result_valid !== 1'b0 || bus.data_result !== 8'd27) begin
            n_fail++; $display("FAIL basic_hold: rv %b data %0d want 0 27", bus.result_valid, bus.data_result);
        end
    endtask

    task automatic test_req1();
        logic [1:0] a; int ca, cr; bit to;
        bus.req = 2'b10; bus.op1 = pk(8'd5, 8'd0, 8'd0, 8'd10);
        wait_ack(5, a, ca, to);
        n_checks++;
        if (to || a !== 2'b10) begin n_fail++; $display("FAIL req1_ack: got %b want 10", a); end
        @(posedge clk); #1;
        bus.req = 2'b00;
        wait_rv(12, cr, to);
        n_checks++;
        if (to || bus.data_result !== 8'd244 || bus.result_id !== 1'b1) begin
            n_fail++; $display("FAIL req1_result: got %0d id %b want 244 id 1", bus.data_result, bus.result_id);
        end
    endtask

    task automatic test_arb();
        logic [1:0] a; int c1, c2, cr; bit to;
        bus.req = 2'b11;
        bus.op0 = pk(8'd1, 8'd2, 8'd3, 8'd4);
        bus.op1 = pk(8'd5, 8'd0, 8'd0, 8'd10);
        pulse_reset();
        wait_ack(5, a, c1, to);
        n_checks++;
        if (to || a !== 2'b01) begin n_fail++; $display("FAIL arb_first: got %b want 01", a); end
        @(posedge clk); #1;
        bus.req = 2'b10;
        wait_rv(12, cr, to);
        n_checks++;
        if (to || bus.data_result !== 8'd27 || bus.result_id !== 1'b0) begin
            n_fail++; $display("FAIL arb_res0: got %0d id %b want 27 id 0", bus.data_result, bus.result_id);
        end
        wait_ack(6, a, c2, to);
        n_checks++;
        if (to || a !== 2'b10) begin n_fail++; $display("FAIL arb_second: got %b want 10", a); end
        n_checks++;
        if (c2 - c1 != 8) begin n_fail++; $display("FAIL arb_spacing: got %0d want 8", c2 - c1); end
        @(posedge clk); #1;
        bus.req = 2'b00;
        wait_rv(12, cr, to);
        n_checks++;
        if (to || bus.data_result !== 8'd244 || bus.result_id !== 1'b1) begin
            n_fail++; $display("FAIL arb_res1: got %0d id %b want 244 id 1", bus.data_result, bus.result_id);
        end
        bus.req = 2'b11;
        wait_ack(5, a, c1, to);
        n_checks++;
        if (to || a !== 2'b01) begin n_fail++; $display("FAIL arb_third: got %b want 01", a); end
        @(posedge clk); #1;
        bus.req = 2'b00;
        wait_rv(12, cr, to);
    endtask

    task automatic test_boundary();
        logic [4*W-1:0] ops [4];
        logic [W-1:0]   exp [4];
        logic [1:0] a; int ca, cr; bit to;
        ops[0] = pk(8'd200, 8'd7, 8'd9, 8'd0);  exp[0] = 8'd9;
        ops[1] = pk(8'd16, 8'd16, 8'd1, 8'd16); exp[1] = 8'd1;
        ops[2] = pk(8'd0, 8'd0, 8'd5, 8'd9);    exp[2] = 8'd5;
        ops[3] = pk(8'd0, 8'd0, 8'd0, 8'd0);    exp[3] = 8'd0;
        for (int i = 0; i < 4; i++) begin
            bus.req = 2'b01; bus.op0 = ops[i];
            wait_ack(5, a, ca, to);
            n_checks++;
            if (to || a !== 2'b01) begin n_fail++; $display("FAIL bound_ack[%0d]: got %b want 01", i, a); end
            @(posedge clk); #1;
            bus.req = 2'b00;
            wait_rv(12, cr, to);
            n_checks++;
            if (to || bus.data_result !== exp[i] || bus.result_id !== 1'b0) begin
                n_fail++; $display("FAIL bound_result[%0d]: got %0d id %b timeout %b want %0d id 0",
                                   i, bus.data_result, bus.result_id, to, exp[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [1:0] a; int ca, cr; bit to, saw;
        bus.req = 2'b01; bus.op0 = pk(8'd1, 8'd2, 8'd3, 8'd4);
        wait_ack(5, a, ca, to);
        @(posedge clk); #1;
        bus.req = 2'b00;
        wait_rv(12, cr, to);
        n_checks++;
        if (to || bus.data_result !== 8'd27) begin n_fail++; $display("FAIL mid_pre: got %0d want 27", bus.data_result); end
        bus.req = 2'b01; bus.op0 = pk(8'd3, 8'd3, 8'd3, 8'd3);
        wait_ack(5, a, ca, to);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.data_result, bus.result_id, bus.busy, bus.result_valid, bus.ack} !== 13'd0) begin
            n_fail++; $display("FAIL mid_clear: data %0d id %b busy %b rv %b ack %b want all 0",
                               bus.data_result, bus.result_id, bus.busy, bus.result_valid, bus.ack);
        end
        bus.req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) saw = 1'b1;
        end
        n_checks++;
        if (saw) begin n_fail++; $display("FAIL mid_no_rv: got rv pulse want none"); end
        bus.req = 2'b01;
        wait_ack(5, a, ca, to);
        @(posedge clk); #1;
        bus.req = 2'b00;
        wait_rv(12, cr, to);
        n_checks++;
        if (to || bus.data_result !== 8'd39 || bus.result_id !== 1'b0) begin
            n_fail++; $display("FAIL mid_fresh: got %0d id %b want 39 id 0", bus.data_result, bus.result_id);
        end
    endtask

    task automatic test_random();
        logic [1:0] a; int ca, cr; bit to;
        logic exp_g;
        logic [4*W-1:0] job;
        bus.req = 2'b11;
        bus.op0 = {$urandom()};
        bus.op1 = {$urandom()};
        pulse_reset();
        exp_g = 1'b0;
        for (int j = 0; j < 1000; j++) begin
            wait_ack(12, a, ca, to);
            n_checks++;
            if (to || a !== (exp_g ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL rand_ack[%0d]: got %b want %b", j, a, exp_g ? 2'b10 : 2'b01);
                break;
            end
            job = exp_g ? bus.op1 : bus.op0;
            @(posedge clk); #1;
            if (exp_g) bus.op1 = {$urandom()};
            else       bus.op0 = {$urandom()};
            wait_rv(10, cr, to);
            n_checks++;
            if (to || bus.data_result !== model(job) || bus.result_id !== exp_g) begin
                n_fail++; $display("FAIL rand_result[%0d]: got %0d id %b want %0d id %b",
                                   j, bus.data_result, bus.result_id, model(job), exp_g);
                break;
            end
            exp_g = ~exp_g;
        end
        bus.req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req1();
        test_arb();
        test_boundary();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
